// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule controller: accepts a cipher key and streams round keys
// 0..Nr one per handshake, deriving each next key through aes_roundkey.

// One step of the AES key expansion, producing the next 128-bit round key.
// AES-128: prev_key and current_key both carry round key RD-1.
// AES-256: prev_key is round key RD-2, current_key is round key RD-1.
module aes_roundkey (
  input  logic [3:0]   rd,
  input  logic [1:0]   mode,
  input  logic [127:0] prev_key,
  input  logic [127:0] current_key,
  output logic [127:0] round_key
);

  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // AES-256 odd rounds use SubWord only; even rounds use Rcon[RD/2]
  always_comb begin
    if (mode == 2'b10 && rd[0])
      temp = sub_word(current_key[31:0]);
    else if (mode == 2'b10)
      temp = sub_word(rot_word(current_key[31:0])) ^ {rcon(rd >> 1), 24'h000000};
    else
      temp = sub_word(rot_word(current_key[31:0])) ^ {rcon(rd), 24'h000000};
    n0 = prev_key[127:96] ^ temp;
    n1 = prev_key[95:64]  ^ n0;
    n2 = prev_key[63:32]  ^ n1;
    n3 = prev_key[31:0]   ^ n2;
    round_key = {n0, n1, n2, n3};
  end

endmodule

module aes_key_sched_ctrl #(
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key_in,
  input  logic [1:0]   mode,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy,
  output logic         err
);

  // DONE is kept in the encoding but never entered: the last handshake
  // returns straight to IDLE so a new key can be taken the next cycle.
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] prev_r, cur_r, rk_data_r, next_key, rk_prev;
  logic [3:0]   idx_r, nr_r, rd;
  logic [1:0]   mode_r;
  logic         rk_last_r, err_r, mode_ok, last_hs;

  assign mode_ok = (mode == 2'b00) || (SUPPORT_256 && mode == 2'b10);
  assign rd      = idx_r + 4'd1;
  assign rk_prev = (mode_r == 2'b10) ? prev_r : cur_r;
  assign last_hs = rk_ready && (idx_r == nr_r);
  assign rk_data = rk_data_r;
  assign rk_idx  = idx_r;
  assign rk_last = rk_last_r;
  assign err     = err_r;

  aes_roundkey u_roundkey (
    .rd          (rd),
    .mode        (mode_r),
    .prev_key    (rk_prev),
    .current_key (cur_r),
    .round_key   (next_key)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the handshake/status outputs derived from state
  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid && mode_ok) state_d = EMIT;
      end
      EMIT: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Key registers: load on accept, advance one round key per handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r    <= '0;
      cur_r     <= '0;
      rk_data_r <= '0;
      idx_r     <= '0;
      nr_r      <= '0;
      mode_r    <= '0;
      rk_last_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      if (state_q == IDLE && key_valid) begin
        if (!mode_ok) begin
          err_r <= 1'b1;
        end else begin
          mode_r    <= mode;
          idx_r     <= '0;
          rk_last_r <= 1'b0;
          rk_data_r <= key_in[255:128];
          if (mode == 2'b10) begin
            prev_r <= key_in[255:128];
            cur_r  <= key_in[127:0];
            nr_r   <= 4'd14;
          end else begin
            cur_r <= key_in[255:128];
            nr_r  <= 4'd10;
          end
        end
      end else if (state_q == EMIT && rk_ready) begin
        if (idx_r == nr_r) begin
          idx_r     <= '0;
          rk_last_r <= 1'b0;
        end else begin
          idx_r     <= rd;
          rk_last_r <= (rd == nr_r);
          if (mode_r == 2'b10 && idx_r == 4'd0) begin
            rk_data_r <= cur_r;
          end else begin
            rk_data_r <= next_key;
            prev_r    <= cur_r;
            cur_r     <= next_key;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl using FIPS-197 expansion vectors.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [255:0] key_in = '0;
  logic [1:0]   mode = 2'b00;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;
  logic         err;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  typedef struct {
    logic [255:0] key;
    logic [1:0]   mode;
    bit           expect_err;
    bit           is256;
    bit           backpressure;
  } vec_t;

  exp_t         exp_q[$];
  vec_t         vecs[7];
  logic [127:0] exp128[11];
  logic [127:0] exp256[15];
  int           checks = 0;
  int           failures = 0;

  logic         held_valid = 1'b0;
  logic [127:0] held_data;
  logic [3:0]   held_idx;

  aes_key_sched_ctrl #(.SUPPORT_256(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .mode      (mode),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and hold-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid && rk_valid) begin
        checkOutput("hold_data", rk_data, held_data);
        checkOutput("hold_idx", 128'(rk_idx), 128'(held_idx));
      end
      if (rk_valid && rk_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_key: got idx %0d data %h expected none", rk_idx, rk_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("rk_data", rk_data, e.data);
          checkOutput("rk_idx", 128'(rk_idx), 128'(e.idx));
          checkOutput("rk_last", 128'(rk_last), 128'(e.last));
        end
      end
      held_valid = rk_valid && !rk_ready;
      held_data  = rk_data;
      held_idx   = rk_idx;
    end
  end

  task automatic push_expected(input bit is256);
    int n;
    n = is256 ? 15 : 11;
    for (int k = 0; k < n; k++)
      exp_q.push_back('{data: (is256 ? exp256[k] : exp128[k]), idx: 4'(k), last: (k == n - 1)});
  endtask

  task automatic recover();
    exp_q.delete();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget, input bit bp);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (bp) rk_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    rk_ready = 1'b1;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d keys pending expected 0", exp_q.size());
      recover();
    end
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int n;
    n = 0;
    while (rk_idx != target && n < 40) begin
      tick();
      n++;
    end
    checkOutput("reach_idx", 128'(rk_idx), 128'(target));
  endtask

  task automatic applyStimulus(input vec_t v);
    rk_ready = v.backpressure ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!v.expect_err) push_expected(v.is256);
    key_in    = v.key;
    mode      = v.mode;
    key_valid = 1'b1;
    checkOutput("key_ready_idle", 128'(key_ready), 128'd1);
    tick();
    key_valid = 1'b0;
    if (v.expect_err) begin
      checkOutput("err_pulse", 128'(err), 128'd1);
      checkOutput("err_no_valid", 128'(rk_valid), 128'd0);
      checkOutput("err_key_ready", 128'(key_ready), 128'd1);
      tick();
      checkOutput("err_clear", 128'(err), 128'd0);
      checkOutput("err_still_idle", 128'(rk_valid), 128'd0);
    end else begin
      checkOutput("first_valid", 128'(rk_valid), 128'd1);
      checkOutput("busy_on", 128'(busy), 128'd1);
      checkOutput("key_ready_busy", 128'(key_ready), 128'd0);
      drain(600, v.backpressure);
      checkOutput("done_key_ready", 128'(key_ready), 128'd1);
      checkOutput("done_valid", 128'(rk_valid), 128'd0);
      checkOutput("done_busy", 128'(busy), 128'd0);
    end
  endtask

  initial begin
    exp128 = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
               128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
               128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
               128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
               128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    exp256 = '{128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
               128'h9ba354118e6925afa51a8b5f2067fcde, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
               128'hd59aecb85bf3c917fee94248de8ebe96, 128'hb5a9328a2678a647983122292f6c79b3,
               128'h812c81addadf48ba24360af2fab8b464, 128'h98c5bfc9bebd198e268c3ba709e04214,
               128'h68007bacb2df331696e939e46c518d80, 128'hc814e20476a9fb8a5025c02d59c58239,
               128'hde1369676ccc5a71fa2563959674ee15, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
               128'h749c47ab18501ddae2757e4f7401905a, 128'hcafaaae3e4d59b349adf6acebd10190d,
               128'hfe4890d1e6188d0b046df344706c631e};

    vecs[0] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeefcafef00d0123456789abcdef},
                mode: 2'b00, expect_err: 1'b0, is256: 1'b0, backpressure: 1'b0};
    vecs[1] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                mode: 2'b10, expect_err: 1'b0, is256: 1'b1, backpressure: 1'b0};
    vecs[2] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                mode: 2'b01, expect_err: 1'b1, is256: 1'b0, backpressure: 1'b0};
    vecs[3] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                mode: 2'b11, expect_err: 1'b1, is256: 1'b0, backpressure: 1'b0};
    vecs[4] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                mode: 2'b10, expect_err: 1'b0, is256: 1'b1, backpressure: 1'b1};
    vecs[5] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                mode: 2'b00, expect_err: 1'b0, is256: 1'b0, backpressure: 1'b1};
    vecs[6] = vecs[1];

    // Reset values
    tick();
    tick();
    checkOutput("rst_key_ready", 128'(key_ready), 128'd1);
    checkOutput("rst_rk_valid", 128'(rk_valid), 128'd0);
    checkOutput("rst_rk_data", rk_data, 128'd0);
    checkOutput("rst_rk_idx", 128'(rk_idx), 128'd0);
    checkOutput("rst_rk_last", 128'(rk_last), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_err", 128'(err), 128'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      tick();
    end

    // Second key offered mid-schedule must be ignored
    rk_ready = 1'b1;
    push_expected(1'b0);
    key_in    = vecs[0].key;
    mode      = 2'b00;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    wait_idx(4'd5);
    key_in    = vecs[1].key;
    mode      = 2'b10;
    key_valid = 1'b1;
    checkOutput("busy_key_ready0", 128'(key_ready), 128'd0);
    tick();
    checkOutput("busy_key_ready1", 128'(key_ready), 128'd0);
    key_valid = 1'b0;
    drain(40, 1'b0);
    checkOutput("after_busy_ready", 128'(key_ready), 128'd1);
    tick();

    // Asynchronous reset at index 7, then a fresh AES-128 schedule
    push_expected(1'b0);
    key_in    = vecs[0].key;
    mode      = 2'b00;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    wait_idx(4'd7);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("arst_rk_valid", 128'(rk_valid), 128'd0);
    checkOutput("arst_rk_idx", 128'(rk_idx), 128'd0);
    checkOutput("arst_rk_data", rk_data, 128'd0);
    checkOutput("arst_key_ready", 128'(key_ready), 128'd1);
    checkOutput("arst_busy", 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    applyStimulus(vecs[0]);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
